// File: rtl/rlc_wr_sched_if.sv
// Signal bundle between the run-length coder scheduler and its environment:
// upstream block handshake, coder record path, host read port and SRAM port.
interface rlc_wr_sched_if #(
    parameter int DATA_W = 107,
    parameter int ADDR_W = 10
);
    logic              start;
    logic [ADDR_W:0]   num_blocks;
    logic              blk_valid;
    logic              blk_ready;
    logic              rlc_enable;
    logic              rlc_valid;
    logic [DATA_W-1:0] rlc_wdata;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  start, num_blocks, blk_valid, rlc_valid, rlc_wdata, rd_req, rd_addr,
        output blk_ready, rlc_enable, rd_gnt, sram_wen, sram_addr, sram_wdata,
               busy, done, err
    );

    modport master (
        output start, num_blocks, blk_valid, rlc_valid, rlc_wdata, rd_req, rd_addr,
        input  blk_ready, rlc_enable, rd_gnt, sram_wen, sram_addr, sram_wdata,
               busy, done, err
    );
endinterface

// File: rtl/rlc_wr_sched.sv
// Sequences blocks into the run-length coder, buffers its records in a small FIFO
// and writes them to the coefficient SRAM, sharing the port with host reads.
module rlc_wr_sched #(
    parameter int DATA_W     = 107,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          srst_n,
    rlc_wr_sched_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]   WR_PRIO = CW'(FIFO_DEPTH - 1);
    localparam logic [ADDR_W:0] MAX_BLK = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_BLK = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [ADDR_W:0]   num_clamped, num_cap, issued;
    logic [ADDR_W-1:0] waddr;
    logic              inflight, live, err_q;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     fifo_cnt, credit_used;
    logic              start_acc, push, pop, spurious;
    logic              blk_ready, rlc_enable, rd_gnt;
    logic              sram_wen_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] sram_wdata_q;

    assign num_clamped = (bus.num_blocks > MAX_BLK) ? MAX_BLK : bus.num_blocks;
    assign start_acc   = (state == IDLE) && bus.start;

    // A block is only accepted if its record is guaranteed a FIFO slot on arrival.
    assign credit_used = fifo_cnt + CW'(inflight);
    assign blk_ready   = (state == RUN) && (issued < num_cap) && (credit_used < DEPTH_C);
    assign rlc_enable  = bus.blk_valid && blk_ready;

    assign push     = bus.rlc_valid && inflight;
    assign spurious = bus.rlc_valid && !inflight;

    // Reads win until the FIFO is one short of full; live keeps rd_gnt low in reset.
    assign pop    = (fifo_cnt != '0) && (!bus.rd_req || (fifo_cnt >= WR_PRIO));
    assign rd_gnt = live && bus.rd_req && !pop;

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    // NOTE: the default assignment up front means no path leaves state_nxt unassigned, so no latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = (num_clamped == '0) ? DONE : RUN;
            RUN:     if (rlc_enable && ((issued + ONE_BLK) == num_cap)) state_nxt = DRAIN;
            DRAIN:   if ((fifo_cnt == '0) && !inflight) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            live     <= 1'b0;
            inflight <= 1'b0;
            num_cap  <= '0;
            issued   <= '0;
            waddr    <= '0;
            err_q    <= 1'b0;
        end else begin
            live     <= 1'b1;
            inflight <= rlc_enable;
            err_q    <= (err_q && !start_acc) || spurious;
            if (start_acc) begin
                num_cap <= num_clamped;
                issued  <= '0;
                waddr   <= '0;
            end else begin
                if (rlc_enable) issued <= issued + ONE_BLK;
                if (pop)        waddr  <= waddr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // NOTE: record storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.rlc_wdata;
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            sram_wen_q   <= 1'b1;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            sram_wen_q <= !pop;
            if (pop) begin
                sram_addr_q  <= waddr;
                sram_wdata_q <= mem[rd_ptr];
            end else if (rd_gnt) begin
                sram_addr_q  <= bus.rd_addr;
            end
        end
    end

    assign bus.blk_ready  = blk_ready;
    assign bus.rlc_enable = rlc_enable;
    assign bus.rd_gnt     = rd_gnt;
    assign bus.sram_wen   = sram_wen_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_wdata = sram_wdata_q;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign bus.err        = err_q;
endmodule

// File: tb/tb_rlc_wr_sched.sv
// Directed bench for rlc_wr_sched: a coder echo model answers each enable one
// cycle later, and SRAM writes are collected for in-order comparison.
module tb_rlc_wr_sched;
    localparam int DATA_W = 107;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic srst_n;
    always #5 clk = ~clk;

    rlc_wr_sched_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rlc_wr_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
        .clk    (clk),
        .srst_n (srst_n),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    int cyc, en_cnt, done_cnt, done_idx;
    logic [ADDR_W-1:0] wa[$];
    logic [DATA_W-1:0] wd[$];
    logic [DATA_W-1:0] rec_q[$];
    bit   spur;
    logic o_ready, o_en, o_rdg, o_wen, o_busy, o_done, o_err;
    logic [ADDR_W-1:0] o_addr;

    // One clock: observe at the falling edge, then drive the next cycle's inputs after the rising edge.
    task automatic step();
        bit en_s;
        @(negedge clk);
        o_ready = bus.blk_ready;
        o_en    = bus.rlc_enable;
        o_rdg   = bus.rd_gnt;
        o_wen   = bus.sram_wen;
        o_addr  = bus.sram_addr;
        o_busy  = bus.busy;
        o_done  = bus.done;
        o_err   = bus.err;
        if (bus.sram_wen === 1'b0) begin
            wa.push_back(bus.sram_addr);
            wd.push_back(bus.sram_wdata);
        end
        if (bus.rlc_enable === 1'b1) en_cnt++;
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_idx = cyc;
        end
        en_s = (bus.rlc_enable === 1'b1);
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.rlc_valid = en_s | spur;
        spur          = 1'b0;
        if (en_s && rec_q.size() > 0) bus.rlc_wdata = rec_q.pop_front();
        cyc++;
    endtask

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        en_cnt   = 0;
        done_cnt = 0;
        done_idx = -1;
        cyc      = 0;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            $display("FAIL done_timeout: got no done within %0d cycles, want a done pulse", budget);
            errors++;
        end
    endtask

    task automatic check_writes(input string name, input int n, input logic [DATA_W-1:0] base);
        checks++;
        if (wa.size() != n) begin
            $display("FAIL %s_count: got %0d writes want %0d", name, wa.size(), n);
            errors++;
        end
        for (int i = 0; i < n && i < wa.size(); i++) begin
            checks++;
            if (wa[i] !== ADDR_W'(i) || wd[i] !== base + DATA_W'(i)) begin
                $display("FAIL %s_write%0d: got addr %0h data %0h want addr %0h data %0h",
                         name, i, wa[i], wd[i], i, base + DATA_W'(i));
                errors++;
            end
        end
    endtask

    task automatic test_reset();
        srst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.start      = 1'($urandom);
            bus.num_blocks = (ADDR_W+1)'($urandom);
            bus.blk_valid  = 1'($urandom);
            bus.rlc_valid  = 1'($urandom);
            bus.rlc_wdata  = {$urandom, $urandom, $urandom, $urandom};
            bus.rd_req     = 1'($urandom);
            bus.rd_addr    = ADDR_W'($urandom);
            #7;
            checks++;
            if ({bus.blk_ready, bus.rlc_enable, bus.rd_gnt, bus.sram_wen, bus.busy, bus.done, bus.err} !== 7'b0001000
                || bus.sram_addr !== '0 || bus.sram_wdata !== '0) begin
                $display("FAIL reset_outputs: got rdy/en/gnt/wen/busy/done/err=%b%b%b%b%b%b%b addr %0h want 0001000 addr 0",
                         bus.blk_ready, bus.rlc_enable, bus.rd_gnt, bus.sram_wen, bus.busy, bus.done, bus.err,
                         bus.sram_addr);
                errors++;
            end
        end
        bus.start = 1'b0; bus.blk_valid = 1'b0; bus.rlc_valid = 1'b0;
        bus.rd_req = 1'b0; bus.num_blocks = '0; bus.rd_addr = '0; bus.rlc_wdata = '0;
        @(negedge clk);
        srst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_mon();
        step();
        step();
        checks++;
        if (o_busy !== 1'b0 || o_wen !== 1'b1 || o_done !== 1'b0) begin
            $display("FAIL reset_release: got busy %b wen %b done %b want 0 1 0", o_busy, o_wen, o_done);
            errors++;
        end
    endtask

    task automatic test_basic();
        clear_mon();
        rec_q = '{107'hA, 107'hB, 107'hC};
        bus.num_blocks = 3;
        bus.blk_valid  = 1'b1;
        bus.start      = 1'b1;
        run_until_done(40);
        bus.blk_valid = 1'b0;
        repeat (3) step();
        checks++;
        if (en_cnt != 3) begin
            $display("FAIL basic_enables: got %0d want 3", en_cnt);
            errors++;
        end
        check_writes("basic", 3, 107'hA);
        checks++;
        if (done_cnt != 1 || done_idx != 7) begin
            $display("FAIL basic_done: got %0d pulses at cycle %0d want 1 at cycle 7", done_cnt, done_idx);
            errors++;
        end
    endtask

    task automatic test_contention();
        logic [10:0] exp_rdy = 11'b000_1101_1110;
        logic [10:0] exp_rdg = 11'b100_1001_1111;
        clear_mon();
        rec_q.delete();
        for (int i = 0; i < 6; i++) rec_q.push_back(107'h100 + DATA_W'(i));
        bus.num_blocks = 6;
        bus.rd_req     = 1'b1;
        bus.rd_addr    = 10'h3FF;
        bus.blk_valid  = 1'b1;
        bus.start      = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            step();
            checks++;
            if (o_ready !== exp_rdy[k] || o_rdg !== exp_rdg[k]) begin
                $display("FAIL contend_cycle%0d: got blk_ready %b rd_gnt %b want %b %b",
                         k, o_ready, o_rdg, exp_rdy[k], exp_rdg[k]);
                errors++;
            end
            if (k == 2) begin
                checks++;
                if (o_wen !== 1'b1 || o_addr !== 10'h3FF) begin
                    $display("FAIL contend_read_addr: got wen %b addr %0h want 1 3ff", o_wen, o_addr);
                    errors++;
                end
            end
        end
        bus.rd_req = 1'b0;
        run_until_done(40);
        bus.blk_valid = 1'b0;
        step();
        checks++;
        if (en_cnt != 6 || done_cnt != 1) begin
            $display("FAIL contend_totals: got %0d enables %0d dones want 6 1", en_cnt, done_cnt);
            errors++;
        end
        check_writes("contend", 6, 107'h100);
    endtask

    task automatic test_zero();
        clear_mon();
        bus.num_blocks = 0;
        bus.blk_valid  = 1'b1;
        bus.start      = 1'b1;
        run_until_done(10);
        repeat (2) step();
        bus.blk_valid = 1'b0;
        checks++;
        if (en_cnt != 0 || wa.size() != 0 || done_cnt != 1 || done_idx != 1) begin
            $display("FAIL zero_run: got en %0d writes %0d dones %0d at %0d want 0 0 1 at 1",
                     en_cnt, wa.size(), done_cnt, done_idx);
            errors++;
        end
    endtask

    task automatic test_spurious();
        clear_mon();
        rec_q.delete();
        bus.rlc_wdata = 107'hDEAD;
        spur = 1'b1;
        repeat (3) step();
        checks++;
        if (o_err !== 1'b1) begin
            $display("FAIL spur_err_set: got %b want 1", o_err);
            errors++;
        end
        step();
        checks++;
        if (o_err !== 1'b1 || wa.size() != 0) begin
            $display("FAIL spur_sticky: got err %b writes %0d want 1 0", o_err, wa.size());
            errors++;
        end
        rec_q.push_back(107'h55);
        bus.num_blocks = 1;
        bus.blk_valid  = 1'b1;
        bus.start      = 1'b1;
        step();
        step();
        checks++;
        if (o_err !== 1'b0) begin
            $display("FAIL spur_err_clear: got %b want 0", o_err);
            errors++;
        end
        run_until_done(20);
        bus.blk_valid = 1'b0;
        check_writes("spur", 1, 107'h55);
    endtask

    task automatic test_mid_reset();
        int n = 0;
        clear_mon();
        rec_q.delete();
        for (int i = 0; i < 5; i++) rec_q.push_back(107'h200 + DATA_W'(i));
        bus.num_blocks = 5;
        bus.blk_valid  = 1'b1;
        bus.start      = 1'b1;
        while (en_cnt < 2 && n < 20) begin
            step();
            n++;
        end
        srst_n        = 1'b0;
        bus.blk_valid = 1'b0;
        bus.rlc_valid = 1'b0;
        #1;
        checks++;
        if ({bus.blk_ready, bus.rlc_enable, bus.rd_gnt, bus.sram_wen, bus.busy, bus.done, bus.err} !== 7'b0001000
            || bus.sram_addr !== '0 || bus.sram_wdata !== '0) begin
            $display("FAIL midreset_outputs: got rdy/en/gnt/wen/busy/done/err=%b%b%b%b%b%b%b want 0001000",
                     bus.blk_ready, bus.rlc_enable, bus.rd_gnt, bus.sram_wen, bus.busy, bus.done, bus.err);
            errors++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.sram_wen !== 1'b1) begin
            $display("FAIL midreset_hold: got done %b wen %b want 0 1", bus.done, bus.sram_wen);
            errors++;
        end
        @(negedge clk);
        srst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_mon();
        rec_q.delete();
        rec_q = '{107'h300, 107'h301};
        bus.num_blocks = 2;
        bus.blk_valid  = 1'b1;
        bus.start      = 1'b1;
        run_until_done(30);
        bus.blk_valid = 1'b0;
        repeat (2) step();
        check_writes("midreset", 2, 107'h300);
    endtask

    initial begin
        spur = 1'b0;
        test_reset();
        test_basic();
        test_contention();
        test_zero();
        test_spurious();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end
endmodule
